store_buffer: RTL and testbench

- Posted-write buffer between the single-cycle core's data-memory port and a slower, handshaked external data memory.
- Consumes the core's per-cycle memory request: MemWrite, MemRead, ALU_Result as the address, ReadData2 as the store data.
- Queues stores so the core does not wait on each write.
- Forwards buffered data to loads; stalls the core on buffer full or load miss.

---
 rtl/store_buffer.sv | 187 ++++++++++++++++++
 tb/tb_store_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and a handshaked external data memory.
// Define STORE_BUF_FWD_EN to forward queued store data to loads; otherwise loads drain the buffer.
module store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_mem_write,
   input  logic        cpu_mem_read,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        buf_empty
);

   typedef enum logic [1:0] {StIdle, StWr, StRd, StResp} state_e;

   localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

   state_e           state_q, state_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d;
   logic [31:0]      mem_wdata_q, mem_wdata_d;
   logic [31:0]      rdata_q, rdata_d;

   logic [29:0]      ent_addr_q [DEPTH];
   logic [31:0]      ent_data_q [DEPTH];

   logic             full, push, pop, load, rd_start;
   logic             unused_addr_bits;

   assign full             = (count_q == Full);
   assign push             = cpu_mem_write && !full;
   assign load             = cpu_mem_read && !cpu_mem_write;
   assign buf_empty        = (count_q == '0);
   assign unused_addr_bits = ^cpu_addr[1:0];

`ifdef STORE_BUF_FWD_EN
   logic        fwd_hit;
   logic [31:0] fwd_data;

   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      // Scan oldest to youngest so the youngest matching entry wins.
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (((PTR_W + 1)'(i) < count_q) &&
             (ent_addr_q[rd_ptr_q + PTR_W'(i)] == cpu_addr[31:2])) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data_q[rd_ptr_q + PTR_W'(i)];
         end
      end
   end

   assign rd_start = load && !fwd_hit;
`else
   // Without comparators a load may only read memory once every queued store has landed.
   assign rd_start = load && (count_q == '0);
`endif

   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = rdata_q;
`ifdef STORE_BUF_FWD_EN
      if (state_q != StResp) begin
         cpu_rdata = fwd_data;
      end
`endif
      if (rst) begin
         cpu_stall = 1'b0;
      end else if (cpu_mem_write) begin
         cpu_stall = full;
      end else if (cpu_mem_read && (state_q != StResp)) begin
`ifdef STORE_BUF_FWD_EN
         cpu_stall = !fwd_hit;
`else
         cpu_stall = 1'b1;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      pop         = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rd_start) begin
               state_d    = StRd;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = {cpu_addr[31:2], 2'b00};
            end else if (count_q != '0) begin
               state_d     = StWr;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {ent_addr_q[rd_ptr_q], 2'b00};
               mem_wdata_d = ent_data_q[rd_ptr_q];
            end
         end
         StWr: begin
            if (mem_ack) begin
               pop       = 1'b1;
               mem_req_d = 1'b0;
               state_d   = StIdle;
            end
         end
         StRd: begin
            if (mem_ack) begin
               rdata_d   = mem_rdata;
               mem_req_d = 1'b0;
               state_d   = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   // Entry storage needs no reset; validity is tracked by count_q and the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         ent_addr_q[wr_ptr_q] <= cpu_addr[31:2];
         ent_data_q[wr_ptr_q] <= cpu_wdata;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: architectural memory model for loads, store-order queue for
// memory writes, plus directed stall/latency/reset checks. Works with or without STORE_BUF_FWD_EN.
module tb_store_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_mem_write, cpu_mem_read;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        buf_empty;

   store_buffer #(
      .DEPTH(DEPTH),
      .PTR_W(PTR_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cpu_mem_write(cpu_mem_write),
      .cpu_mem_read (cpu_mem_read),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_rdata    (cpu_rdata),
      .cpu_stall    (cpu_stall),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .buf_empty    (buf_empty)
   );

   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   logic [31:0] ext_mem  [logic [31:0]];  // external memory contents
   logic [31:0] arch_mem [logic [31:0]];  // memory as the core should observe it
   logic [63:0] exp_wr_q [$];             // expected write stream {addr, data}
   logic [31:0] exp_rd_q [$];             // expected load results

   int ack_dly    = 2;
   bit ack_hold   = 1'b0;
   bit stray_ack  = 1'b0;
   int wr_seen    = 0;
   int rd_seen_at = -1;
   bit in_flight  = 1'b0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: acks ack_dly cycles after a request is first seen.
   initial begin
      int cnt;
      cnt       = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (stray_ack) begin
            mem_ack = 1'b1;
         end else if (rst || !mem_req) begin
            cnt = 0;
         end else if (!ack_hold && cnt >= ack_dly) begin
            mem_ack = 1'b1;
            cnt     = 0;
            if (mem_we) ext_mem[mem_addr] = mem_wdata;
            else mem_rdata = ext_mem.exists(mem_addr) ? ext_mem[mem_addr] : dflt(mem_addr);
         end else begin
            cnt++;
         end
      end
   end

   // Monitor: compares completed loads and newly issued memory writes against the queues.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_flight = 1'b0;
         end else begin
            if (cpu_mem_read && !cpu_mem_write && !cpu_stall) begin
               if (exp_rd_q.size() == 0) check("unexpected_load", 32'd1, 32'd0);
               else check("load_data", cpu_rdata, exp_rd_q.pop_front());
            end
            if (mem_req && !in_flight) begin
               in_flight = 1'b1;
               if (mem_we) begin
                  wr_seen++;
                  if (exp_wr_q.size() == 0) begin
                     check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
                  end else begin
                     e = exp_wr_q.pop_front();
                     check("write_addr", mem_addr, e[63:32]);
                     check("write_data", mem_wdata, e[31:0]);
                  end
               end else begin
                  rd_seen_at = wr_seen;
               end
            end
            if (mem_ack) in_flight = 1'b0;
         end
      end
   end

   task automatic wait_go(input string name, output int stalls);
      stalls = 0;
      @(negedge clk);
      while (cpu_stall && stalls < 300) begin
         stalls++;
         @(negedge clk);
      end
      if (cpu_stall) check(name, 32'd1, 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      exp_wr_q.push_back({w, d});
      arch_mem[w]   = d;
      cpu_mem_write = 1'b1;
      cpu_addr      = a;
      cpu_wdata     = d;
      wait_go("store_timeout", stalls);
      cpu_mem_write = 1'b0;
   endtask

   task automatic do_load(input logic [31:0] a, output int stalls);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      exp_rd_q.push_back(arch_mem.exists(w) ? arch_mem[w] : dflt(w));
      cpu_mem_read = 1'b1;
      cpu_addr     = a;
      wait_go("load_timeout", stalls);
      cpu_mem_read = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(buf_empty && !mem_req) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", {31'b0, buf_empty && !mem_req}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int st, wb;
      logic [31:0] a;
      rst           = 1'b1;
      cpu_mem_write = 1'b0;
      cpu_mem_read  = 1'b1;
      cpu_addr      = 32'h0000_0300;
      cpu_wdata     = '0;
      ext_mem[32'h40]  = 32'h0000_DEAD;
      arch_mem[32'h40] = 32'h0000_DEAD;

      // Reset state, and stall forced low while in reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_buf_empty", {31'b0, buf_empty}, 32'd1);
      check("rst_stall", {31'b0, cpu_stall}, 32'd0);
      cpu_mem_read = 1'b0;
      rst          = 1'b0;

      // Three posted stores, no stall, written in order
      ack_dly = 2;
      do_store(32'h10, 32'hA, st);
      check("st0_stall", st, 0);
      do_store(32'h14, 32'hB, st);
      check("st1_stall", st, 0);
      do_store(32'h18, 32'hC, st);
      check("st2_stall", st, 0);
      wait_idle();
      check("drain_empty", {31'b0, buf_empty}, 32'd1);

      // Fill the buffer with ack held off; the fifth store stalls until a pop
      ack_hold = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_store(32'h80 + 32'(i) * 32'd4, 32'h100 + 32'(i), st);
         check("fill_stall", st, 0);
      end
      fork
         do_store(32'h90, 32'h104, st);
         begin
            repeat (6) @(posedge clk);
            #1;
            ack_hold = 1'b0;
         end
      join
      check("full_stall", {31'b0, st > 0}, 32'd1);
      wait_idle();

      // Two stores to one word, then a load of it
      ack_hold   = 1'b1;
      rd_seen_at = -1;
      wb         = wr_seen;
      do_store(32'h20, 32'h11, st);
      do_store(32'h20, 32'h22, st);
`ifdef STORE_BUF_FWD_EN
      do_load(32'h20, st);
      check("hit_stall", st, 0);
      ack_hold = 1'b0;
      wait_idle();
      check("hit_no_read", rd_seen_at, 32'hFFFF_FFFF);
`else
      fork
         do_load(32'h20, st);
         begin
            repeat (3) @(posedge clk);
            #1;
            ack_hold = 1'b0;
         end
      join
      check("nofwd_stalled", {31'b0, st > 0}, 32'd1);
      check("nofwd_read_after_drain", rd_seen_at, wb + 2);
      wait_idle();
`endif

      // Load miss on an empty buffer: ack three cycles after req, five stall cycles
      ack_dly = 3;
      do_load(32'h40, st);
      check("miss_latency", st, 5);
      wait_idle();

      // Load miss behind a held write with two more queued
      ack_dly    = 1;
      ack_hold   = 1'b1;
      rd_seen_at = -1;
      do_store(32'h50, 32'h50, st);
      do_store(32'h54, 32'h54, st);
      do_store(32'h58, 32'h58, st);
      @(posedge clk);
      #1;
      wb = wr_seen;
      fork
         do_load(32'h44, st);
         begin
            repeat (3) @(posedge clk);
            #1;
            ack_hold = 1'b0;
         end
      join
`ifdef STORE_BUF_FWD_EN
      check("read_before_writes", rd_seen_at, wb);
`else
      check("read_after_writes", rd_seen_at, wb + 2);
`endif
      wait_idle();

      // Random stores and loads over a small window: wraps pointers, mixes hits and misses
      for (int k = 0; k < 80; k++) begin
         a       = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
         ack_dly = int'($urandom_range(0, 3));
         if ($urandom_range(0, 2) != 0) do_store(a, $urandom, st);
         else do_load(a, st);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      wait_idle();

      // Reset while a write is outstanding with three entries
      ack_hold = 1'b1;
      do_store(32'h200, 32'h1, st);
      do_store(32'h204, 32'h2, st);
      do_store(32'h208, 32'h3, st);
      rst          = 1'b1;
      cpu_mem_read = 1'b1;
      cpu_addr     = 32'h300;
      @(negedge clk);
      check("rst_stall_forced", {31'b0, cpu_stall}, 32'd0);
      @(posedge clk);
      #1;
      check("midrst_mem_req", {31'b0, mem_req}, 32'd0);
      check("midrst_buf_empty", {31'b0, buf_empty}, 32'd1);
      cpu_mem_read = 1'b0;
      rst          = 1'b0;
      ack_hold     = 1'b0;
      exp_wr_q.delete();
      @(negedge clk);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("stray_ack_empty", {31'b0, buf_empty}, 32'd1);
      check("stray_ack_no_req", {31'b0, mem_req}, 32'd0);
      ack_dly = 1;
      do_store(32'h60, 32'h77, st);
      check("post_rst_store_stall", st, 0);
      do_load(32'h60, st);
      wait_idle();

      check("pending_writes", exp_wr_q.size(), 32'd0);
      check("pending_loads", exp_rd_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
